// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: operand fetch and ID/EX pipeline register for the RV32 core.
//
// Purpose:
//   - Drives the register-file read addresses straight from the decoder.
//   - Picks each source operand from x0, the MEM bypass, the WB bypass or the
//     register file.
//   - Stalls on load-use hazards.
//   - Holds the instruction for the execute unit under a valid/ready handshake.
//   - A branch mispredict (flush) kills the held instruction.
//
// Configuration macro: OPERAND_FWD_EN
//   defined   : MEM/WB bypassing; only load-use dependencies stall.
//   undefined : no bypassing; any pending writer of a source stalls until the
//               register file holds the committed value.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   in_valid/in_ready          decoder handshake
//   in_pc, in_inst             instruction address / word
//   in_rs1/rs2/rd, in_use_rs*  register indices and source-use flags
//   in_reg_wen, in_is_load     instruction writes rd / is a load
//   rf_rs1/rf_rs2, rf_valA/B   register-file read port
//   mem_*                      EX/MEM register status, destination, ALU result
//   wb_*                       MEM/WB register status, destination, writeback value
//   flush                      branch mispredict
//   out_valid/out_ready        execute-unit handshake
//   out_*                      registered instruction fields and operands
module id_ex_operand_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_inst,
  input  logic [REG_WIDTH-1:0] in_rs1,
  input  logic [REG_WIDTH-1:0] in_rs2,
  input  logic [REG_WIDTH-1:0] in_rd,
  input  logic                 in_use_rs1,
  input  logic                 in_use_rs2,
  input  logic                 in_reg_wen,
  input  logic                 in_is_load,
  output logic [REG_WIDTH-1:0] rf_rs1,
  output logic [REG_WIDTH-1:0] rf_rs2,
  input  logic [WIDTH-1:0]     rf_valA,
  input  logic [WIDTH-1:0]     rf_valB,
  input  logic                 mem_valid,
  input  logic                 mem_reg_wen,
  input  logic                 mem_is_load,
  input  logic [REG_WIDTH-1:0] mem_rd,
  input  logic [WIDTH-1:0]     mem_data,
  input  logic                 wb_valid,
  input  logic                 wb_reg_wen,
  input  logic [REG_WIDTH-1:0] wb_rd,
  input  logic [WIDTH-1:0]     wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_inst,
  output logic [REG_WIDTH-1:0] out_rd,
  output logic                 out_reg_wen,
  output logic                 out_is_load,
  output logic [WIDTH-1:0]     out_valA,
  output logic [WIDTH-1:0]     out_valB
);

  localparam int unsigned XLEN = 32;

  // Pipeline register state
  logic                 out_valid_q,   out_valid_d;
  logic [XLEN-1:0]      out_pc_q,      out_pc_d;
  logic [XLEN-1:0]      out_inst_q,    out_inst_d;
  logic [REG_WIDTH-1:0] out_rd_q,      out_rd_d;
  logic                 out_reg_wen_q, out_reg_wen_d;
  logic                 out_is_load_q, out_is_load_d;
  logic [WIDTH-1:0]     out_val_a_q,   out_val_a_d;
  logic [WIDTH-1:0]     out_val_b_q,   out_val_b_d;

  logic                 out_m1, out_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic                 hazard;
  logic [WIDTH-1:0]     op_a, op_b;

  // A pending writer in some stage targets a source this instruction reads
  function automatic logic src_match(input logic                 stg_valid,
                                     input logic                 stg_wen,
                                     input logic [REG_WIDTH-1:0] stg_rd,
                                     input logic [REG_WIDTH-1:0] src,
                                     input logic                 use_src);
    return stg_valid && stg_wen && (stg_rd == src) && (src != '0) && use_src;
  endfunction

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  assign out_m1 = src_match(out_valid_q, out_reg_wen_q, out_rd_q, in_rs1, in_use_rs1);
  assign out_m2 = src_match(out_valid_q, out_reg_wen_q, out_rd_q, in_rs2, in_use_rs2);
  assign mem_m1 = src_match(mem_valid, mem_reg_wen, mem_rd, in_rs1, in_use_rs1);
  assign mem_m2 = src_match(mem_valid, mem_reg_wen, mem_rd, in_rs2, in_use_rs2);
  assign wb_m1  = src_match(wb_valid, wb_reg_wen, wb_rd, in_rs1, in_use_rs1);
  assign wb_m2  = src_match(wb_valid, wb_reg_wen, wb_rd, in_rs2, in_use_rs2);

`ifdef OPERAND_FWD_EN
  // Only load data cannot be bypassed in time: load in EX or in MEM stalls
  assign hazard = ((out_m1 || out_m2) && out_is_load_q) ||
                  ((mem_m1 || mem_m2) && mem_is_load);
`else
  // Without bypass, wait until no stage still owes a write to a source
  assign hazard = out_m1 || out_m2 || mem_m1 || mem_m2 || wb_m1 || wb_m2;

  logic unused_fwd;
  assign unused_fwd = ^{mem_data, wb_data, mem_is_load};
`endif

  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);

  // Operand select: x0, then MEM (non-load), then WB, then register file.
  // WB must bypass because the register file writes on this same edge.
  always_comb begin
    op_a = rf_valA;
    op_b = rf_valB;
`ifdef OPERAND_FWD_EN
    if (mem_m1 && !mem_is_load) op_a = mem_data;
    else if (wb_m1)             op_a = wb_data;
    if (mem_m2 && !mem_is_load) op_b = mem_data;
    else if (wb_m2)             op_b = wb_data;
`endif
    if (in_rs1 == '0) op_a = '0;
    if (in_rs2 == '0) op_b = '0;
  end

  // Next state of the ID/EX register
  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_inst_d    = out_inst_q;
    out_rd_d      = out_rd_q;
    out_reg_wen_d = out_reg_wen_q;
    out_is_load_d = out_is_load_q;
    out_val_a_d   = out_val_a_q;
    out_val_b_d   = out_val_b_q;
    if (flush || !out_valid_q || out_ready) begin
      if (flush) begin
        out_valid_d = 1'b0;
      end else if (in_valid && in_ready) begin
        out_valid_d   = 1'b1;
        out_pc_d      = in_pc;
        out_inst_d    = in_inst;
        out_rd_d      = in_rd;
        out_reg_wen_d = in_reg_wen;
        out_is_load_d = in_is_load;
        out_val_a_d   = op_a;
        out_val_b_d   = op_b;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_inst_q    <= '0;
      out_rd_q      <= '0;
      out_reg_wen_q <= 1'b0;
      out_is_load_q <= 1'b0;
      out_val_a_q   <= '0;
      out_val_b_q   <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_inst_q    <= out_inst_d;
      out_rd_q      <= out_rd_d;
      out_reg_wen_q <= out_reg_wen_d;
      out_is_load_q <= out_is_load_d;
      out_val_a_q   <= out_val_a_d;
      out_val_b_q   <= out_val_b_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_inst    = out_inst_q;
  assign out_rd      = out_rd_q;
  assign out_reg_wen = out_reg_wen_q;
  assign out_is_load = out_is_load_q;
  assign out_valA    = out_val_a_q;
  assign out_valB    = out_val_b_q;

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Operand-fetch and ID/EX pipeline register for the five-stage RV32 core. It sits between the decoder and the execute unit, and drives the register file read addresses. It picks each operand from the register file or bypasses it from the MEM and WB stages. It detects load-use hazards and stalls, and applies branch-mispredict flushes under a valid/ready handshake.

## Interface
- WIDTH, 32, datapath width
- REG_WIDTH, 5, register index width
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid / in_ready  input / output  1 / 1  decoder handshake
- in_pc, in_inst  input  32 each  instruction address and word
- in_rs1, in_rs2, in_rd  input  REG_WIDTH each  register indices
- in_use_rs1, in_use_rs2  input  1 each  the instruction actually reads that source
- in_reg_wen, in_is_load  input  1 each  writes rd; is a load
- rf_rs1, rf_rs2  output  REG_WIDTH each  register-file read addresses
- rf_valA, rf_valB  input  WIDTH each  register-file read data
- mem_valid, mem_reg_wen, mem_is_load  input  1 each  EX/MEM-register status
- mem_rd  input  REG_WIDTH  EX/MEM destination
- mem_data  input  WIDTH  EX/MEM ALU result
- wb_valid, wb_reg_wen  input  1 each  MEM/WB-register status
- wb_rd  input  REG_WIDTH  MEM/WB destination
- wb_data  input  WIDTH  writeback value
- flush  input  1  branch mispredict; kills the held instruction
- out_valid / out_ready  output / input  1 / 1  execute-unit handshake
- out_pc, out_inst  output  32 each  registered
- out_rd  output  REG_WIDTH  registered
- out_reg_wen, out_is_load  output  1 each  registered
- out_valA, out_valB  output  WIDTH each  registered operands

## Operation
- rf_rs1 = in_rs1 and rf_rs2 = in_rs2, combinational pass-through.
- A source "matches" a stage when all of the following hold: the stage is valid, its reg_wen = 1, its rd = the source index, the source index ≠ 0, and in_use_rsX = 1.
- Operand select, per source:
  - index 0 → 0;
  - else a MEM match with mem_is_load = 0 → mem_data;
  - else a WB match → wb_data;
  - else rf_valA / rf_valB.
- MEM takes priority over WB.
- The WB bypass is mandatory: the register file writes on the same edge, so its read returns stale data that cycle.
- Hazard (stall) when either source matches:
  - the held output instruction, with out_valid = 1 and out_is_load = 1; or
  - MEM, with mem_is_load = 1.
- Accept condition: in_ready = !flush && !hazard && (!out_valid || out_ready).
- Register update, at each edge where flush = 1 or (!out_valid || out_ready):
  - flush = 1 → out_valid ← 0;
  - else in_valid && in_ready → load all out_* fields, out_valid ← 1;
  - else → out_valid ← 0 (bubble).
- Otherwise all out_* fields hold.
- Reset: out_valid = 0 and all other out_* = 0. Reset takes effect immediately (asynchronous) and overrides flush and the handshake.

## Timing
- Latency: accepted at edge N → visible on out_* after edge N, one cycle.
- Back-to-back throughput is 1 per cycle with no hazard.
- Load-use stall:
  - dependent instruction right behind a load: 2 bubble cycles (load in EX, then in MEM);
  - one instruction between them: 1 bubble cycle;
  - then the operand bypasses from WB.
- out_* must be stable while out_valid = 1 && out_ready = 0.
- Flush concurrent with in_valid: the instruction is not accepted, and out_valid = 0 next cycle.
- rst asserted mid-stall clears out_valid asynchronously. in_ready returns per the accept condition once rst deasserts.

## Configuration
- OPERAND_FWD_EN defined: bypassing as described above.
- OPERAND_FWD_EN undefined:
  - no bypass, operands always come from rf_valA / rf_valB (0 for x0);
  - any match (held output, MEM, or WB, load or not) is a hazard;
  - the stall lasts until the writer has committed, i.e. the cycle after the WB match clears.

## Test plan
- Reset, then out_ready = 1, stream of 3 independent instructions (pc 0x0, 0x4, 0x8) → out_valid rises one cycle after each accept, in order, with no bubbles.
- x5 held in MEM with mem_data = 0x1234 and in WB with wb_data = 0x9999 → out_valA = 0x1234 (MEM priority). MEM valid dropped → 0x9999.
- Load to x6 held on the output register, next instruction reads x6 → in_ready = 0 for 2 cycles. Then the operand equals wb_data = 0xCAFE.
- flush = 1 while out_valid = 1 and in_valid = 1 → out_valid = 0 next cycle, in_ready = 0 during flush.
- out_ready = 0 for 3 cycles with a valid output → out_* unchanged and in_ready = 0. out_ready = 1 → advances.
- Writer with rd = 0 in MEM (mem_data = 0x5555), instruction reads x0 → operand 0 and no stall. OPERAND_FWD_EN undefined with a non-load writer to x7 in MEM → stall until the cycle after WB commits.
